ucc_8bit: RTL and testbench
===========================

UCC_8BIT -- requirements
Module: ucc_8bit

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 cin  input  1  carry/serial input; carry-in for arithmetic, fill bit for shifts.
REQ-005 fin  input  8  primary operand F, unsigned.
REQ-006 pin  input  8  secondary operand P, unsigned; ignored in shift modes.
REQ-007 m  input  2  operation select.
REQ-008 cout  output  1  registered carry/shift-out.
REQ-009 fout  output  8  registered result.
REQ-010 mo  output  2  registered copy of m, for cascading further stages.

Function
REQ-011 The block SHALL sample cin, fin, pin and m on each rising clk edge with rst_n=1.
- It SHALL present {cout, fout, mo} for the sampled operation after that edge.
- Latency: exactly 1 cycle; throughput: 1 operation per cycle.
REQ-012 m=0 (ADD) SHALL produce {cout,fout} = fin + pin + cin, as a 9-bit unsigned sum.
REQ-013 m=3 (SUB) SHALL produce {cout,fout} = fin + ~pin + cin.
- With cin=1, fout = (fin - pin) mod 256.
- cout=1 means no borrow (fin >= pin); cout=0 means borrow.
REQ-014 m=1 (SHL) SHALL produce fout = {fin[6:0], cin} and cout = fin[7].
REQ-015 m=2 (SHR) SHALL produce fout = {cin, fin[7:1]} and cout = fin[0].
REQ-016 mo SHALL equal the m value sampled in the same cycle as fout/cout.
REQ-017 Results SHALL wrap modulo 256; overflow is reported only through cout, with no saturation.
REQ-018 A change of m between cycles SHALL take effect on the next edge, with no pipeline flush or bubble.
REQ-019 Outputs SHALL hold their value only until the next clock edge; no enable input exists.

Reset
REQ-020 When rst_n=0 at a rising edge, fout SHALL become 8'h00, cout 0 and mo 2'b00.
REQ-021 Reset SHALL override any operation sampled in the same cycle.
REQ-022 The first valid result SHALL appear 1 cycle after the first edge with rst_n=1.
REQ-023 Reset SHALL NOT act asynchronously; outputs are unchanged between edges while rst_n=0.

Structure
REQ-024 A shared package SHALL define:
- the 2-bit mode type;
- the constants MODE_ADD=0, MODE_SHL=1, MODE_SHR=2, MODE_SUB=3;
- the width parameter W=8.
REQ-025 The datapath SHALL be built from 8 instances of one sub-module, ucc_cell.
- Each ucc_cell is a 1-bit combinational cell.
- Inputs: f, p, carry-in, left-neighbour f, right-neighbour f, and mode.
- Outputs: result bit and carry-out.
REQ-026 The ucc_cell carry SHALL ripple from bit 0 to bit 7.
- The bit-7 carry-out (ADD/SUB) or the shifted-out bit (SHL/SHR) SHALL feed cout.
REQ-027 The top level SHALL contain only the cell chain, the mode-dependent boundary muxing and the output registers.

Verification
REQ-028 The bench SHALL cover these directed scenarios, each checked 1 cycle after the inputs are applied:
- Reset held, then released -> fout=0, cout=0, mo=0.
- cin=1, m=0, fin=7, pin=10 -> fout=18, cout=0, mo=0.
- cin=1, m=3, fin=7, pin=12 -> fout=251, cout=0 (borrow), mo=3.
- cin=1, m=1, fin=7 -> fout=15, cout=0; fin=16 -> fout=33, cout=0; fin=79 -> fout=159, cout=0; mo=1.
- cin=1, m=2, fin=7 -> fout=131, cout=1; fin=16 -> fout=136, cout=0; fin=80 -> fout=168, cout=0; mo=2.
- cin=0, m=0, fin=255, pin=1 -> fout=0, cout=1.
  - Then assert rst_n=0 mid-stream -> fout=0, cout=0, mo=0 on the next edge.

Source files
------------

// File: rtl/ucc_8bit_pkg.sv
// ============================================================================
// Module  : ucc_8bit_pkg
// Brief   : Shared mode type, mode constants and datapath width for ucc_8bit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ucc_8bit_pkg;

  localparam int W = 8;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD = 2'd0;
  localparam mode_t MODE_SHL = 2'd1;
  localparam mode_t MODE_SHR = 2'd2;
  localparam mode_t MODE_SUB = 2'd3;

endpackage : ucc_8bit_pkg

`default_nettype wire

// File: rtl/ucc_8bit_if.sv
// ============================================================================
// Module  : ucc_8bit_if
// Brief   : Operand/result bundle for ucc_8bit; master drives operands.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ucc_8bit_if;
  import ucc_8bit_pkg::*;

  logic         cin;
  logic [W-1:0] fin;
  logic [W-1:0] pin;
  mode_t        m;
  logic         cout;
  logic [W-1:0] fout;
  mode_t        mo;

  modport master (output cin, fin, pin, m, input cout, fout, mo);
  modport slave  (input cin, fin, pin, m, output cout, fout, mo);

endinterface : ucc_8bit_if

`default_nettype wire

// File: rtl/ucc_8bit_cell.sv
// ============================================================================
// Module  : ucc_cell
// Brief   : 1-bit combinational slice: full adder/subtractor or shift mux.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ucc_cell
  import ucc_8bit_pkg::*;
(
  input  logic  f,
  input  logic  p,
  input  logic  ci,
  input  logic  fl,    // f of the next-higher bit
  input  logic  fr,    // f of the next-lower bit
  input  mode_t mode,
  output logic  r,
  output logic  co
);

  logic w_pe;

  // SHL emits its own f as carry so bit 7 yields the shifted-out MSB;
  // SHR forwards the incoming carry so the LSB injected at bit 0 reaches the top.
  always_comb begin
    w_pe = (mode == MODE_SUB) ? ~p : p;
    r    = f ^ w_pe ^ ci;
    co   = (f & w_pe) | (ci & (f ^ w_pe));
    case (mode)
      MODE_SHL: begin
        r  = fr;
        co = f;
      end
      MODE_SHR: begin
        r  = fl;
        co = ci;
      end
      default: ;
    endcase
  end

endmodule : ucc_cell

`default_nettype wire

// File: rtl/ucc_8bit.sv
// ============================================================================
// Module  : ucc_8bit
// Brief   : Registered 8-bit add/sub/shift unit built from a ucc_cell chain.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ucc_8bit
  import ucc_8bit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ucc_8bit_if.slave    bus
);

  logic [W-1:0] w_left;
  logic [W-1:0] w_right;
  logic [W:0]   w_carry;
  logic [W-1:0] w_res;

  logic [W-1:0] r_fout;
  logic         r_cout;
  mode_t        r_mo;

  // cin fills the vacated end of either shift; in SHR the chain carries fin[0] up to cout.
  assign w_left     = {bus.cin, bus.fin[W-1:1]};
  assign w_right    = {bus.fin[W-2:0], bus.cin};
  assign w_carry[0] = (bus.m == MODE_SHR) ? bus.fin[0] : bus.cin;

  generate
    for (genvar i = 0; i < W; i++) begin : g_cell
      ucc_cell u_cell (
        .f    (bus.fin[i]),
        .p    (bus.pin[i]),
        .ci   (w_carry[i]),
        .fl   (w_left[i]),
        .fr   (w_right[i]),
        .mode (bus.m),
        .r    (w_res[i]),
        .co   (w_carry[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fout <= '0;
      r_cout <= 1'b0;
      r_mo   <= MODE_ADD;
    end else begin
      r_fout <= w_res;
      r_cout <= w_carry[W];
      r_mo   <= bus.m;
    end
  end

  assign bus.fout = r_fout;
  assign bus.cout = r_cout;
  assign bus.mo   = r_mo;

endmodule : ucc_8bit

`default_nettype wire

// File: tb/tb_ucc_8bit.sv
// ============================================================================
// Module  : tb_ucc_8bit
// Brief   : Scoreboard bench for ucc_8bit with directed and random operations.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ucc_8bit;
  import ucc_8bit_pkg::*;

  typedef struct packed {
    logic [7:0] f;
    logic       c;
    logic [1:0] m;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  ucc_8bit_if bus ();

  ucc_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic r, input logic c, input int f,
                                 input int p, input int mm);
    exp_t e;
    int   s;
    e = '0;
    if (r) begin
      case (mm)
        0: s = f + p + int'(c);
        3: s = f + (255 - p) + int'(c);
        1: s = ((f * 2) % 256 + int'(c)) + (f / 128) * 256;
        default: s = (f / 2 + int'(c) * 128) + (f % 2) * 256;
      endcase
      e.f = 8'(s % 256);
      e.c = (s >= 256);
      e.m = 2'(mm);
    end
    return e;
  endfunction

  task automatic drive_exp(input logic r, input logic c, input logic [7:0] f,
                           input logic [7:0] p, input logic [1:0] mm, input exp_t e);
    @(negedge clk);
    rst_n   = r;
    bus.cin = c;
    bus.fin = f;
    bus.pin = p;
    bus.m   = mm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic c, input logic [7:0] f,
                       input logic [7:0] p, input logic [1:0] mm);
    drive_exp(r, c, f, p, mm, model(r, c, int'(f), int'(p), int'(mm)));
  endtask

  // Monitor: results appear every edge; also confirm outputs hold mid-cycle.
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      got = {bus.fout, bus.cout, bus.mo};
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL result: got fout=%0d cout=%0b mo=%0d, expected fout=%0d cout=%0b mo=%0d",
                   bus.fout, bus.cout, bus.mo, e.f, e.c, e.m);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.fout, bus.cout, bus.mo} !== got) begin
          n_bad++;
          $display("FAIL hold: got %0h between edges, expected %0h", {bus.fout, bus.cout, bus.mo}, got);
        end
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    rst_n   = 1'b0;
    bus.cin = 1'b0;
    bus.fin = '0;
    bus.pin = '0;
    bus.m   = MODE_ADD;

    // Reset held with a live operation applied, then released.
    drive_exp(1'b0, 1'b1, 8'd200, 8'd100, MODE_SUB, '{8'd0, 1'b0, 2'd0});
    drive_exp(1'b0, 1'b1, 8'd255, 8'd255, MODE_ADD, '{8'd0, 1'b0, 2'd0});
    drive_exp(1'b1, 1'b1, 8'd7,   8'd10,  MODE_ADD, '{8'd18,  1'b0, 2'd0});
    drive_exp(1'b1, 1'b1, 8'd7,   8'd12,  MODE_SUB, '{8'd251, 1'b0, 2'd3});
    drive_exp(1'b1, 1'b1, 8'd7,   8'd0,   MODE_SHL, '{8'd15,  1'b0, 2'd1});
    drive_exp(1'b1, 1'b1, 8'd16,  8'd0,   MODE_SHL, '{8'd33,  1'b0, 2'd1});
    drive_exp(1'b1, 1'b1, 8'd79,  8'd0,   MODE_SHL, '{8'd159, 1'b0, 2'd1});
    drive_exp(1'b1, 1'b1, 8'd7,   8'd0,   MODE_SHR, '{8'd131, 1'b1, 2'd2});
    drive_exp(1'b1, 1'b1, 8'd16,  8'd0,   MODE_SHR, '{8'd136, 1'b0, 2'd2});
    drive_exp(1'b1, 1'b1, 8'd80,  8'd0,   MODE_SHR, '{8'd168, 1'b0, 2'd2});
    drive_exp(1'b1, 1'b0, 8'd255, 8'd1,   MODE_ADD, '{8'd0,   1'b1, 2'd0});
    drive_exp(1'b0, 1'b1, 8'd255, 8'd255, MODE_SUB, '{8'd0,   1'b0, 2'd0});
    // Boundary cases: shifted-out MSB/LSB set, SUB without borrow, equal operands.
    drive_exp(1'b1, 1'b0, 8'd128, 8'd0,   MODE_SHL, '{8'd0,   1'b1, 2'd1});
    drive_exp(1'b1, 1'b0, 8'd1,   8'd0,   MODE_SHR, '{8'd0,   1'b1, 2'd2});
    drive_exp(1'b1, 1'b1, 8'd12,  8'd7,   MODE_SUB, '{8'd5,   1'b1, 2'd3});
    drive_exp(1'b1, 1'b1, 8'd99,  8'd99,  MODE_SUB, '{8'd0,   1'b1, 2'd3});
    drive_exp(1'b1, 1'b1, 8'd255, 8'd255, MODE_ADD, '{8'd255, 1'b1, 2'd0});

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom));
    end
    drive(1'b1, 1'b0, 8'd0, 8'd0, MODE_ADD);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_ucc_8bit

`default_nettype wire
